// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the datapath and the control FSM: bus source
//            select codes, strobe bit positions and ALU operation codes.
// Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Bus source select codes (read_en)
  localparam logic [3:0] RD_PC     = 4'd1;
  localparam logic [3:0] RD_AR     = 4'd2;
  localparam logic [3:0] RD_IR     = 4'd4;
  localparam logic [3:0] RD_AC     = 4'd5;
  localparam logic [3:0] RD_R      = 4'd6;
  localparam logic [3:0] RD_R1     = 4'd7;
  localparam logic [3:0] RD_R2     = 4'd8;
  localparam logic [3:0] RD_R3     = 4'd9;
  localparam logic [3:0] RD_R4     = 4'd10;
  localparam logic [3:0] RD_DM     = 4'd12;
  localparam logic [3:0] RD_IM     = 4'd13;
  localparam logic [3:0] RD_AC_ALT = 4'd14;

  // Strobe bit positions shared by write_en, inc_en and clr_en
  localparam int unsigned WB_PC   = 1;
  localparam int unsigned WB_AR   = 2;
  localparam int unsigned WB_IR   = 3;
  localparam int unsigned WB_AC   = 4;
  localparam int unsigned WB_R    = 5;
  localparam int unsigned WB_R4   = 7;
  localparam int unsigned WB_R3   = 8;
  localparam int unsigned WB_R2   = 9;
  localparam int unsigned WB_R1   = 10;
  localparam int unsigned WB_DMWE = 11;  // write_en only: data memory write
  localparam int unsigned WB_ALU  = 12;  // write_en only: AC <- ALU result
  localparam int unsigned WB_R_AC = 13;  // write_en only: R  <- AC

  // ALU operations; codes 5..7 behave as pass-through
  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_MUL  = 3'd3,
    ALU_SHL  = 3'd4
  } alu_op_e;

  // Next value of a plain register: clear beats bus load beats increment
  function automatic logic [15:0] reg_next(input logic [15:0] cur,
                                           input logic [15:0] bus_val,
                                           input logic        clr,
                                           input logic        wr,
                                           input logic        inc);
    logic [15:0] nxt;
    nxt = cur;
    if (clr)      nxt = 16'h0000;
    else if (wr)  nxt = bus_val;
    else if (inc) nxt = cur + 16'd1;
    return nxt;
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// ============================================================================
// Module   : dp_alu
// Brief    : Combinational 16-bit ALU over AC and R; carries and overflow are
//            dropped, unnamed opcodes pass AC through.
// Revision : 1.0  initial release
// ============================================================================
module dp_alu
  import cpu_pkg::*;
(
  input  logic [15:0] ac,
  input  logic [15:0] r,
  input  logic [2:0]  alu_op,
  output logic [15:0] result
);

  // Operation select; the product keeps only its low 16 bits
  always_comb begin
    result = ac;
    case (alu_op)
      ALU_ADD: result = ac + r;
      ALU_SUB: result = ac - r;
      ALU_MUL: result = ac * r;
      ALU_SHL: result = {ac[14:0], 1'b0};
      default: result = ac;
    endcase
  end

endmodule : dp_alu
`default_nettype wire

// File: rtl/datapath_regbank.sv
`default_nettype none
// ============================================================================
// Module   : datapath_regbank
// Brief    : CPU register bank and shared bus: PC, AR, IR, AC, R, R1..R4 and
//            the zero flag, with per-register clear/load/increment strobes.
// Revision : 1.0  initial release
// ============================================================================
module datapath_regbank
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  read_en,
  input  logic [15:0] write_en,
  input  logic [15:0] inc_en,
  input  logic [15:0] clr_en,
  input  logic [2:0]  alu_op,
  input  logic [15:0] im_rdata,
  input  logic [15:0] dm_rdata,
  output logic [15:0] im_addr,
  output logic [15:0] dm_addr,
  output logic [15:0] dm_wdata,
  output logic        dm_we,
  output logic [15:0] bus,
  output logic [15:0] z,
  output logic [4:0]  instruction
);

  logic [15:0] r_pc, r_ar, r_ir, r_ac, r_r;
  logic [15:0] r_r1, r_r2, r_r3, r_r4;
  logic        r_zf;

  logic [15:0] w_bus;
  logic [15:0] w_alu;
  logic [15:0] w_ac_next;
  logic [15:0] w_r_next;
  logic        w_ac_upd;
  logic        w_unused_strobes;

  dp_alu u_alu (
    .ac     (r_ac),
    .r      (r_r),
    .alu_op (alu_op),
    .result (w_alu)
  );

  // Bus source mux; reads always see the pre-edge register contents
  always_comb begin
    w_bus = 16'h0000;
    case (read_en)
      RD_PC:            w_bus = r_pc;
      RD_AR:            w_bus = r_ar;
      RD_IR:            w_bus = r_ir;
      RD_AC, RD_AC_ALT: w_bus = r_ac;
      RD_R:             w_bus = r_r;
      RD_R1:            w_bus = r_r1;
      RD_R2:            w_bus = r_r2;
      RD_R3:            w_bus = r_r3;
      RD_R4:            w_bus = r_r4;
      RD_DM:            w_bus = dm_rdata;
      RD_IM:            w_bus = im_rdata;
      default:          w_bus = 16'h0000;
    endcase
  end

  // AC next value: clear, then ALU result, then bus load, then increment
  always_comb begin
    w_ac_next = r_ac;
    if (clr_en[WB_AC])          w_ac_next = 16'h0000;
    else if (write_en[WB_ALU])  w_ac_next = w_alu;
    else if (write_en[WB_AC])   w_ac_next = w_bus;
    else if (inc_en[WB_AC])     w_ac_next = r_ac + 16'd1;
  end

  // R next value: clear, then bus load, then copy of AC, then increment
  always_comb begin
    w_r_next = r_r;
    if (clr_en[WB_R])           w_r_next = 16'h0000;
    else if (write_en[WB_R])    w_r_next = w_bus;
    else if (write_en[WB_R_AC]) w_r_next = r_ac;
    else if (inc_en[WB_R])      w_r_next = r_r + 16'd1;
  end

  // ZF only follows AC on edges where some AC strobe is active
  assign w_ac_upd = clr_en[WB_AC] | write_en[WB_ALU] | write_en[WB_AC] | inc_en[WB_AC];

  // Register bank state; reset zeroes everything and sets ZF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= 16'h0000;
      r_ar <= 16'h0000;
      r_ir <= 16'h0000;
      r_ac <= 16'h0000;
      r_r  <= 16'h0000;
      r_r1 <= 16'h0000;
      r_r2 <= 16'h0000;
      r_r3 <= 16'h0000;
      r_r4 <= 16'h0000;
      r_zf <= 1'b1;
    end else begin
      r_pc <= reg_next(r_pc, w_bus, clr_en[WB_PC], write_en[WB_PC], inc_en[WB_PC]);
      r_ar <= reg_next(r_ar, w_bus, clr_en[WB_AR], write_en[WB_AR], inc_en[WB_AR]);
      r_ir <= reg_next(r_ir, w_bus, clr_en[WB_IR], write_en[WB_IR], inc_en[WB_IR]);
      r_r1 <= reg_next(r_r1, w_bus, clr_en[WB_R1], write_en[WB_R1], inc_en[WB_R1]);
      r_r2 <= reg_next(r_r2, w_bus, clr_en[WB_R2], write_en[WB_R2], inc_en[WB_R2]);
      r_r3 <= reg_next(r_r3, w_bus, clr_en[WB_R3], write_en[WB_R3], inc_en[WB_R3]);
      r_r4 <= reg_next(r_r4, w_bus, clr_en[WB_R4], write_en[WB_R4], inc_en[WB_R4]);
      r_ac <= w_ac_next;
      r_r  <= w_r_next;
      if (w_ac_upd) begin
        r_zf <= (w_ac_next == 16'h0000);
      end
    end
  end

  // Strobe positions with no function in this block
  assign w_unused_strobes = ^{write_en[15:14], write_en[6], write_en[0],
                              inc_en[15:11], inc_en[6], inc_en[0],
                              clr_en[15:11], clr_en[6], clr_en[0]};

  assign bus         = w_bus;
  assign dm_wdata    = w_bus;
  assign im_addr     = r_pc;
  assign dm_addr     = r_ar;
  // Memory write is suppressed while reset is held
  assign dm_we       = write_en[WB_DMWE] & rst_n;
  assign z           = {15'h0000, r_zf};
  assign instruction = r_ir[4:0];

endmodule : datapath_regbank
`default_nettype wire

// File: tb/tb_datapath_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_regbank
// Brief    : Self-checking bench for datapath_regbank: vector table with an
//            expectation queue, plus an asynchronous reset sequence.
// Revision : 1.0  initial release
// ============================================================================
module tb_datapath_regbank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_rdata, dm_rdata;
  logic [15:0] im_addr, dm_addr, dm_wdata, bus, z;
  logic        dm_we;
  logic [4:0]  instruction;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [15:0] B1  = 16'h0002, B2  = 16'h0004, B3  = 16'h0008;
  localparam logic [15:0] B4  = 16'h0010, B5  = 16'h0020, B6  = 16'h0040;
  localparam logic [15:0] B7  = 16'h0080, B8  = 16'h0100, B9  = 16'h0200;
  localparam logic [15:0] B10 = 16'h0400, B11 = 16'h0800, B12 = 16'h1000;
  localparam logic [15:0] B13 = 16'h2000;

  datapath_regbank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_en     (read_en),
    .write_en    (write_en),
    .inc_en      (inc_en),
    .clr_en      (clr_en),
    .alu_op      (alu_op),
    .im_rdata    (im_rdata),
    .dm_rdata    (dm_rdata),
    .im_addr     (im_addr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_we       (dm_we),
    .bus         (bus),
    .z           (z),
    .instruction (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  re;
    logic [15:0] we, ie, ce;
    logic [2:0]  op;
    logic [15:0] data;
    logic [15:0] exp_bus;
    logic        exp_dmwe;
    logic [15:0] exp_pc, exp_ar;
    logic [4:0]  exp_instr;
    logic [15:0] exp_z;
  } vec_t;

  typedef struct {
    logic [15:0] bus;
    logic        dmwe;
    logic [15:0] pc, ar;
    logic [4:0]  instr;
    logic [15:0] z;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] re, input logic [15:0] we,
                              input logic [15:0] ie, input logic [15:0] ce,
                              input logic [2:0] op, input logic [15:0] data,
                              input logic [15:0] eb, input logic edw,
                              input logic [15:0] epc, input logic [15:0] ear,
                              input logic ez);
    vec_t v;
    v.re = re; v.we = we; v.ie = ie; v.ce = ce; v.op = op; v.data = data;
    v.exp_bus = eb; v.exp_dmwe = edw; v.exp_pc = epc; v.exp_ar = ear;
    v.exp_instr = 5'd19; v.exp_z = {15'h0000, ez};
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] re, input logic [15:0] we, input logic [15:0] ie,
                       input logic [15:0] ce, input logic [2:0] op, input logic [15:0] data);
    read_en = re; write_en = we; inc_en = ie; clr_en = ce; alu_op = op;
    im_rdata = data; dm_rdata = data;
  endtask

  initial begin
    exp_t e;
    string tag;
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0);
    rst_n = 1'b0;

    // Vector table: state after reset is all zero with ZF set
    vecs.push_back(mk(4'd13, B3,  0,  0,  3'd0, 16'h0013, 16'h0013, 0, 16'h0000, 16'h0000, 1)); // fetch IR
    vecs.push_back(mk(4'd4,  0,   B1, 0,  3'd0, 16'h0000, 16'h0013, 0, 16'h0001, 16'h0000, 1)); // PC++
    vecs.push_back(mk(4'd12, B4,  0,  0,  3'd0, 16'h0003, 16'h0003, 0, 16'h0001, 16'h0000, 0)); // AC=3
    vecs.push_back(mk(4'd12, B5,  0,  0,  3'd0, 16'h0005, 16'h0005, 0, 16'h0001, 16'h0000, 0)); // R=5
    vecs.push_back(mk(4'd5,  B12, 0,  0,  3'd3, 16'h0000, 16'h0003, 0, 16'h0001, 16'h0000, 0)); // AC=3*5
    vecs.push_back(mk(4'd5,  B13, 0,  0,  3'd0, 16'h0000, 16'h000F, 0, 16'h0001, 16'h0000, 0)); // R=AC
    vecs.push_back(mk(4'd6,  B12, 0,  0,  3'd2, 16'h0000, 16'h000F, 0, 16'h0001, 16'h0000, 1)); // AC-R=0
    vecs.push_back(mk(4'd12, B4,  0,  0,  3'd0, 16'hFFFF, 16'hFFFF, 0, 16'h0001, 16'h0000, 0)); // AC=FFFF
    vecs.push_back(mk(4'd5,  0,   B4, 0,  3'd0, 16'h0000, 16'hFFFF, 0, 16'h0001, 16'h0000, 1)); // wrap
    vecs.push_back(mk(4'd12, B1,  0,  B1, 3'd0, 16'h1234, 16'h1234, 0, 16'h0000, 16'h0000, 1)); // clr>wr
    vecs.push_back(mk(4'd12, B4,  0,  0,  3'd0, 16'h00AA, 16'h00AA, 0, 16'h0000, 16'h0000, 0)); // AC=AA
    vecs.push_back(mk(4'd12, B2,  0,  0,  3'd0, 16'h0040, 16'h0040, 0, 16'h0000, 16'h0040, 0)); // AR=40
    vecs.push_back(mk(4'd5,  B11, 0,  0,  3'd0, 16'h0000, 16'h00AA, 1, 16'h0000, 16'h0040, 0)); // mem wr
    vecs.push_back(mk(4'd5,  B10, 0,  0,  3'd0, 16'h0000, 16'h00AA, 0, 16'h0000, 16'h0040, 0)); // R1=AC
    vecs.push_back(mk(4'd5,  0,   0,  B4, 3'd0, 16'h0000, 16'h00AA, 0, 16'h0000, 16'h0040, 1)); // clr AC
    vecs.push_back(mk(4'd7,  B4,  0,  0,  3'd0, 16'h0000, 16'h00AA, 0, 16'h0000, 16'h0040, 0)); // AC=R1
    vecs.push_back(mk(4'd3,  B6,  0,  0,  3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0040, 0)); // bit 6
    vecs.push_back(mk(4'd11, 0,   0,  0,  3'd0, 16'h5555, 16'h0000, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd15, 0,   0,  0,  3'd0, 16'h5555, 16'h0000, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd5,  0,   0,  0,  3'd0, 16'h0000, 16'h00AA, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd14, 0,   0,  0,  3'd0, 16'h0000, 16'h00AA, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd12, B7,  0,  0,  3'd0, 16'h0111, 16'h0111, 0, 16'h0000, 16'h0040, 0)); // R4
    vecs.push_back(mk(4'd12, B8,  0,  0,  3'd0, 16'h0222, 16'h0222, 0, 16'h0000, 16'h0040, 0)); // R3
    vecs.push_back(mk(4'd12, B9,  0,  0,  3'd0, 16'h0333, 16'h0333, 0, 16'h0000, 16'h0040, 0)); // R2
    vecs.push_back(mk(4'd8,  0,   0,  0,  3'd0, 16'h0000, 16'h0333, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd9,  0,   0,  0,  3'd0, 16'h0000, 16'h0222, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd10, 0,   0,  0,  3'd0, 16'h0000, 16'h0111, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd2,  0,   0,  0,  3'd0, 16'h0000, 16'h0040, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd1,  0,   0,  0,  3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd12, B5|B13, 0, 0, 3'd0, 16'h0077, 16'h0077, 0, 16'h0000, 16'h0040, 0)); // R: bus>AC
    vecs.push_back(mk(4'd6,  0,   B5, 0,  3'd0, 16'h0000, 16'h0077, 0, 16'h0000, 16'h0040, 0)); // R++
    vecs.push_back(mk(4'd6,  0,   0,  0,  3'd0, 16'h0000, 16'h0078, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd6,  B12, 0,  0,  3'd1, 16'h0000, 16'h0078, 0, 16'h0000, 16'h0040, 0)); // AC=122
    vecs.push_back(mk(4'd5,  B12, 0,  0,  3'd4, 16'h0000, 16'h0122, 0, 16'h0000, 16'h0040, 0)); // AC=244
    vecs.push_back(mk(4'd5,  0,   0,  0,  3'd0, 16'h0000, 16'h0244, 0, 16'h0000, 16'h0040, 0));
    vecs.push_back(mk(4'd5,  B12, 0,  B4, 3'd1, 16'h0000, 16'h0244, 0, 16'h0000, 16'h0040, 1)); // clr>alu
    vecs.push_back(mk(4'd6,  B13, 0,  0,  3'd0, 16'h0000, 16'h0078, 0, 16'h0000, 16'h0040, 1)); // old R
    vecs.push_back(mk(4'd6,  0,   0,  0,  3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0040, 1));

    // Reset state
    #12;
    check("rst_z", z, 16'h0001);
    check("rst_im_addr", im_addr, 16'h0000);
    check("rst_dm_addr", dm_addr, 16'h0000);
    check("rst_instr", {11'h0, instruction}, 16'h0000);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].re, vecs[i].we, vecs[i].ie, vecs[i].ce, vecs[i].op, vecs[i].data);
      e.bus = vecs[i].exp_bus; e.dmwe = vecs[i].exp_dmwe; e.pc = vecs[i].exp_pc;
      e.ar = vecs[i].exp_ar; e.instr = vecs[i].exp_instr; e.z = vecs[i].exp_z;
      sb.push_back(e);
      #3;
      tag = $sformatf("v%0d", i);
      check({tag, "_bus"}, bus, sb[0].bus);
      check({tag, "_dm_wdata"}, dm_wdata, sb[0].bus);
      check({tag, "_dm_we"}, {15'h0, dm_we}, {15'h0, sb[0].dmwe});
      @(posedge clk); #1;
      e = sb.pop_front();
      check({tag, "_im_addr"}, im_addr, e.pc);
      check({tag, "_dm_addr"}, dm_addr, e.ar);
      check({tag, "_instr"}, {11'h0, instruction}, {11'h0, e.instr});
      check({tag, "_z"}, z, e.z);
    end

    // Asynchronous reset in mid-cycle with AC = 1234
    drive(4'd12, B4, 16'h0, 16'h0, 3'd0, 16'h1234);
    @(posedge clk); #1;
    drive(4'd5, B11, 16'h0, 16'h0, 3'd0, 16'h0000);
    #1 check("ar_pre_ac", bus, 16'h1234);
    check("ar_pre_z", z, 16'h0000);
    #1 rst_n = 1'b0;
    #1;
    check("ar_ac", bus, 16'h0000);
    check("ar_z", z, 16'h0001);
    check("ar_dm_we", {15'h0, dm_we}, 16'h0000);
    check("ar_im_addr", im_addr, 16'h0000);
    check("ar_dm_addr", dm_addr, 16'h0000);
    check("ar_instr", {11'h0, instruction}, 16'h0000);
    drive(4'd13, B4, 16'h0, 16'h0, 3'd0, 16'hBEEF);
    #1 check("ar_bus_im", bus, 16'hBEEF);
    repeat (2) @(posedge clk);
    #3;
    check("ar_held_ac", {15'h0, z[0]}, 16'h0001);
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0000);
    #1 check("ar_held_bus", bus, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ac", bus, 16'h0000);
    check("post_rst_z", z, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_datapath_regbank
`default_nettype wire
